register_bank_writer: RTL and testbench
=======================================

Name: register_bank_writer

Overview:
Write side of the register file. It holds NUM_REGS registers of WORD_LENGTH bits and accepts one write per clock through an address decoder. It also runs a sequenced bulk-clear, one register per cycle. All register contents drive a flattened bus that feeds the existing 32-to-1 read multiplexer, so this block is the write-end counterpart of the read path.

Parameters:
WORD_LENGTH, 32, data width of each register
NUM_REGS, 32, number of registers; valid range 2..32
NBITS, CeilLog2(NUM_REGS) = 5, address width; derived, never overridden

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset
Write_Enable  input  1  write request, sampled on rising clk
Write_Register  input  NBITS  destination register index
Write_Data  input  WORD_LENGTH  data to write
Clear_Request  input  1  starts the bulk clear sequence
Reg_Bus  output  NUM_REGS*WORD_LENGTH  flattened contents; register i sits at bits [i*WORD_LENGTH +: WORD_LENGTH]
Write_Ack  output  1  one-cycle pulse confirming an accepted write
Write_Error  output  1  one-cycle pulse flagging a rejected, out-of-range write
Busy  output  1  high while the clear sequence runs

Behaviour:
- Reset (reset=0, asynchronous):
  - all registers, Write_Ack, Write_Error and Busy go to 0.
  - clear counter goes to 0; state goes to IDLE.
  - applies immediately, including mid-clear; the sequence is abandoned.
- States: IDLE and CLEAR.
- IDLE, Write_Enable=1, Clear_Request=0:
  - Write_Register in 1..NUM_REGS-1: register is loaded with Write_Data at the edge; Reg_Bus shows it after that edge (1-cycle latency).
  - Write_Ack is high for exactly the cycle after the edge.
  - Write_Register = 0: register 0 is hardwired to zero, so data is discarded. Write_Ack still pulses.
  - Write_Register >= NUM_REGS (only possible when NUM_REGS is not a power of two): no register changes. Write_Error pulses for one cycle; no Write_Ack.
- IDLE, Clear_Request=1: go to CLEAR at the edge.
  - Clear has priority: a simultaneous write is dropped, with no Ack and no Error.
- CLEAR:
  - Busy=1 from the first cycle after entry.
  - Each edge zeroes register[counter], then counter increments.
  - After register NUM_REGS-1 is zeroed: counter returns to 0, state returns to IDLE, Busy drops. Total NUM_REGS cycles in CLEAR.
  - Writes and Clear_Request arriving during CLEAR are ignored (no Ack, no Error, no restart).
- Back-to-back writes on consecutive cycles are all accepted; each gets its own Ack pulse.
- Write_Ack and Write_Error are registered and never high together.
- No combinational path from inputs to outputs.

Decomposition:
- Shared package holds:
  - the CeilLog2 function;
  - the state encoding (IDLE=1'b0, CLEAR=1'b1);
  - the WORD_LENGTH/NUM_REGS defaults, shared with Mux32to1.
- Sub-module write_decoder:
  - inputs: NBITS address and an enable;
  - output: NUM_REGS one-hot write strobe;
  - strobe bit 0 is forced low.
- Register array and FSM live in the top level.

Test Plan:
- Reset, then write 32'hDEADBEEF to reg 3 -> slice 3 = DEADBEEF one cycle later; Write_Ack high exactly one cycle; all other slices 0.
- Write 32'h12345678 to reg 0 -> slice 0 stays 0; Write_Ack pulses once.
- Write regs 5, 16 and 25 with values 5, 16 and 25 on consecutive cycles -> three Ack pulses; slices match. Cross-check through Mux32to1 with Selector 5, 16, 25.
- Fill all registers, then assert Clear_Request together with a write to reg 7 -> write dropped, no Ack; Busy high for 32 cycles; every slice 0 afterwards; Busy low on cycle 33.
- Drop reset low at clear cycle 10 with regs 20..31 still nonzero -> all slices 0 immediately, Busy 0; next write to reg 31 is accepted normally.
- NUM_REGS=20: write to reg 22 -> Write_Error pulses once; no Ack; Reg_Bus unchanged.

Source files
------------

// File: rtl/register_bank_writer_pkg.sv
// -----------------------------------------------------------------------------
// register_bank_writer_pkg
//   Shared definitions for the register-file write side.
//   - CeilLog2: address width needed to index a given number of registers.
//   - state_e : write-side FSM encoding (IDLE / CLEAR).
//   - DEFAULT_WORD_LENGTH / DEFAULT_NUM_REGS: geometry shared with the
//     Mux32to1 read path so both ends of the register file agree.
// -----------------------------------------------------------------------------
package register_bank_writer_pkg;

    localparam int DEFAULT_WORD_LENGTH = 32;
    localparam int DEFAULT_NUM_REGS    = 32;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_e;

    // Smallest n such that 2**n >= value (value >= 2 in practice).
    function automatic int CeilLog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage : register_bank_writer_pkg

// File: rtl/register_bank_writer_write_decoder.sv
// -----------------------------------------------------------------------------
// write_decoder
//   Turns a register index plus enable into a one-hot write strobe.
//   Register 0 is hardwired to zero, so its strobe bit never asserts.
//   Indices >= NUM_REGS produce an all-zero strobe.
//
//   Ports:
//     addr_i   [NBITS-1:0]    destination register index
//     en_i                    write enable (already qualified by the FSM)
//     strobe_o [NUM_REGS-1:0] one-hot write strobe, bit 0 always low
// -----------------------------------------------------------------------------
module write_decoder
    import register_bank_writer_pkg::*;
#(
    parameter  int NUM_REGS = DEFAULT_NUM_REGS,
    localparam int NBITS    = CeilLog2(NUM_REGS)
) (
    input  logic [NBITS-1:0]    addr_i,
    input  logic                en_i,
    output logic [NUM_REGS-1:0] strobe_o
);

    // NOTE: every output of a combinational block gets a default before any
    // conditional assignment; otherwise the unassigned paths infer latches.
    always_comb begin
        strobe_o = '0;
        // Loop starts at 1: register 0 can never be written.
        for (int i = 1; i < NUM_REGS; i++) begin
            if (en_i && (addr_i == NBITS'(i))) begin
                strobe_o[i] = 1'b1;
            end
        end
    end

endmodule : write_decoder

// File: rtl/register_bank_writer.sv
// -----------------------------------------------------------------------------
// register_bank_writer
//   Write side of the register file: NUM_REGS x WORD_LENGTH registers, one
//   write per clock, plus a sequenced bulk clear (one register per cycle).
//   Contents are exported on a flattened bus for the Mux32to1 read path.
//
//   Ports:
//     clk             rising-edge clock
//     reset           asynchronous, active-low reset
//     Write_Enable    write request
//     Write_Register  destination register index (NBITS)
//     Write_Data      data to write (WORD_LENGTH)
//     Clear_Request   start bulk clear (wins over a simultaneous write)
//     Reg_Bus         flattened contents, reg i at [i*WORD_LENGTH +: WORD_LENGTH]
//     Write_Ack       1-cycle pulse after an accepted write (incl. reg 0)
//     Write_Error     1-cycle pulse after an out-of-range write
//     Busy            high while the clear sequence runs
//   All outputs come straight from flops.
// -----------------------------------------------------------------------------
module register_bank_writer
    import register_bank_writer_pkg::*;
#(
    parameter  int WORD_LENGTH = DEFAULT_WORD_LENGTH,
    parameter  int NUM_REGS    = DEFAULT_NUM_REGS,
    localparam int NBITS       = CeilLog2(NUM_REGS)
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            Write_Enable,
    input  logic [NBITS-1:0]                Write_Register,
    input  logic [WORD_LENGTH-1:0]          Write_Data,
    input  logic                            Clear_Request,
    output logic [NUM_REGS*WORD_LENGTH-1:0] Reg_Bus,
    output logic                            Write_Ack,
    output logic                            Write_Error,
    output logic                            Busy
);

    localparam logic [NBITS-1:0] LAST_REG     = NBITS'(NUM_REGS - 1);
    // One extra bit so NUM_REGS itself is representable when it is a power of two.
    localparam logic [NBITS:0]   NUM_REGS_EXT = (NBITS + 1)'(NUM_REGS);

    state_e                 state_q, state_d;
    logic [NBITS-1:0]       cnt_q, cnt_d;
    logic                   ack_q, ack_d;
    logic                   err_q, err_d;
    logic                   clearing;
    logic                   wr_en;
    logic                   in_range;
    logic [NUM_REGS-1:0]    wr_strobe;
    logic [WORD_LENGTH-1:0] regs_q [NUM_REGS];

    assign in_range = ({1'b0, Write_Register} < NUM_REGS_EXT);

    // A write only reaches the decoder in IDLE and when no clear is requested
    // in the same cycle, so clear always wins and writes during CLEAR vanish.
    assign wr_en = (state_q == IDLE) && Write_Enable && !Clear_Request;

    write_decoder #(
        .NUM_REGS (NUM_REGS)
    ) u_write_decoder (
        .addr_i   (Write_Register),
        .en_i     (wr_en),
        .strobe_o (wr_strobe)
    );

    // ---------------------------------------------------------------- FSM
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        ack_d    = 1'b0;
        err_d    = 1'b0;
        clearing = 1'b0;
        case (state_q)
            IDLE: begin
                if (Clear_Request) begin
                    state_d = CLEAR;
                    cnt_d   = '0;
                end else if (Write_Enable) begin
                    // Reg 0 is in range: its data is discarded but it is acked.
                    ack_d = in_range;
                    err_d = !in_range;
                end
            end
            CLEAR: begin
                clearing = 1'b1;
                if (cnt_q == LAST_REG) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + NBITS'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // NOTE: sequential state is updated with non-blocking assignments so every
    // flop samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
        end
    end

    // ------------------------------------------------------ register array
    // NOTE: this storage is architecturally visible and must read zero right
    // after reset, so it is built from resettable flops rather than a RAM.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            // Reg 0 is never loaded; its clear slot is a no-op cycle that
            // keeps the sequence length at exactly NUM_REGS.
            for (int i = 1; i < NUM_REGS; i++) begin
                if (wr_strobe[i]) begin
                    regs_q[i] <= Write_Data;
                end else if (clearing && (cnt_q == NBITS'(i))) begin
                    regs_q[i] <= '0;
                end
            end
        end
    end

    // ------------------------------------------------------------- outputs
    for (genvar g = 0; g < NUM_REGS; g++) begin : g_bus
        assign Reg_Bus[g*WORD_LENGTH +: WORD_LENGTH] = regs_q[g];
    end

    assign Write_Ack   = ack_q;
    assign Write_Error = err_q;
    assign Busy        = (state_q == CLEAR);

endmodule : register_bank_writer

// File: tb/tb_register_bank_writer.sv
// -----------------------------------------------------------------------------
// tb_register_bank_writer
//   Self-checking bench: a 32-register instance for the main scenarios and a
//   20-register instance for out-of-range writes. Accepted writes are pushed
//   to a scoreboard queue when driven and popped when Write_Ack appears.
// -----------------------------------------------------------------------------
module tb_register_bank_writer;

    localparam int WL = 32;
    localparam int NR = 32;
    localparam int NR20 = 20;

    typedef struct {
        int          idx;
        logic [31:0] data;
    } wr_item_t;

    logic clk = 1'b0;
    logic reset;

    logic              we, cr;
    logic [4:0]        wr;
    logic [31:0]       wd;
    logic [NR*WL-1:0]  bus;
    logic              ack, err, busy;

    logic              we20, cr20;
    logic [4:0]        wr20;
    logic [31:0]       wd20;
    logic [NR20*WL-1:0] bus20;
    logic              ack20, err20, busy20;

    int total = 0;
    int bad   = 0;

    wr_item_t    exp_q[$];
    logic [31:0] model [NR];

    always #5 clk = ~clk;

    register_bank_writer #(.WORD_LENGTH(WL), .NUM_REGS(NR)) dut (
        .clk            (clk),
        .reset          (reset),
        .Write_Enable   (we),
        .Write_Register (wr),
        .Write_Data     (wd),
        .Clear_Request  (cr),
        .Reg_Bus        (bus),
        .Write_Ack      (ack),
        .Write_Error    (err),
        .Busy           (busy)
    );

    register_bank_writer #(.WORD_LENGTH(WL), .NUM_REGS(NR20)) dut20 (
        .clk            (clk),
        .reset          (reset),
        .Write_Enable   (we20),
        .Write_Register (wr20),
        .Write_Data     (wd20),
        .Clear_Request  (cr20),
        .Reg_Bus        (bus20),
        .Write_Ack      (ack20),
        .Write_Error    (err20),
        .Busy           (busy20)
    );

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Read-path reference: what Mux32to1 returns for a given Selector.
    function automatic logic [31:0] mux32(input logic [NR*WL-1:0] b, input logic [4:0] s);
        return b[int'(s)*WL +: WL];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_zero();
        for (int i = 0; i < NR; i++) model[i] = '0;
    endtask

    task automatic drive_write(input int idx, input logic [31:0] data);
        wr_item_t it;
        we = 1'b1;
        wr = 5'(idx);
        wd = data;
        it.idx  = idx;
        it.data = (idx == 0) ? 32'h0 : data;
        exp_q.push_back(it);
    endtask

    // Called right after the edge that captured the driven write.
    task automatic sb_check(input string name);
        wr_item_t it;
        total++;
        if (ack !== (exp_q.size() != 0)) begin
            bad++;
            $display("FAIL %s ack: got %b want %b", name, ack, exp_q.size() != 0);
        end
        total++;
        if (err !== 1'b0) begin
            bad++;
            $display("FAIL %s err: got %b want 0", name, err);
        end
        if (exp_q.size() != 0) begin
            it = exp_q.pop_front();
            model[it.idx] = it.data;
            total++;
            if (bus[it.idx*WL +: WL] !== it.data) begin
                bad++;
                $display("FAIL %s slice%0d: got %h want %h", name, it.idx,
                         bus[it.idx*WL +: WL], it.data);
            end
        end
    endtask

    task automatic compare_bus(input string name);
        logic [NR*WL-1:0] expv;
        for (int i = 0; i < NR; i++) expv[i*WL +: WL] = model[i];
        total++;
        if (bus !== expv) begin
            bad++;
            for (int i = 0; i < NR; i++) begin
                if (bus[i*WL +: WL] !== model[i]) begin
                    $display("FAIL %s slice%0d: got %h want %h", name, i,
                             bus[i*WL +: WL], model[i]);
                    break;
                end
            end
        end
    endtask

    task automatic fill_all(input string name);
        for (int i = 1; i < NR; i++) begin
            drive_write(i, $urandom | 32'h1);
            tick();
            sb_check(name);
        end
        we = 1'b0;
    endtask

    // ---------------------------------------------------------------- tests
    task automatic test_reset();
        reset = 1'b0;
        we = 0; cr = 0; wr = '0; wd = '0;
        we20 = 0; cr20 = 0; wr20 = '0; wd20 = '0;
        model_zero();
        repeat (3) tick();
        compare_bus("reset_bus");
        total++;
        if ({ack, err, busy} !== 3'b000) begin
            bad++;
            $display("FAIL reset_flags: got %b want 000", {ack, err, busy});
        end
        total++;
        if (bus20 !== '0) begin
            bad++;
            $display("FAIL reset_bus20: got nonzero want zero");
        end
        @(negedge clk);
        reset = 1'b1;
        tick();
    endtask

    task automatic test_single_write();
        drive_write(3, 32'hDEADBEEF);
        tick();
        we = 1'b0;
        sb_check("write3");
        compare_bus("write3_bus");
        tick();
        total++;
        if (ack !== 1'b0) begin
            bad++;
            $display("FAIL write3_ack_len: got %b want 0", ack);
        end
    endtask

    task automatic test_reg_zero();
        drive_write(0, 32'h12345678);
        tick();
        we = 1'b0;
        sb_check("write0");
        compare_bus("write0_bus");
        tick();
        total++;
        if (ack !== 1'b0) begin
            bad++;
            $display("FAIL write0_ack_len: got %b want 0", ack);
        end
    endtask

    task automatic test_back_to_back();
        int idxs[3] = '{5, 16, 25};
        for (int k = 0; k < 3; k++) begin
            drive_write(idxs[k], 32'(idxs[k]));
            tick();
            sb_check("b2b");
        end
        we = 1'b0;
        tick();
        total++;
        if (ack !== 1'b0) begin
            bad++;
            $display("FAIL b2b_ack_end: got %b want 0", ack);
        end
        for (int k = 0; k < 3; k++) begin
            total++;
            if (mux32(bus, 5'(idxs[k])) !== 32'(idxs[k])) begin
                bad++;
                $display("FAIL b2b_mux sel=%0d: got %h want %h", idxs[k],
                         mux32(bus, 5'(idxs[k])), 32'(idxs[k]));
            end
        end
        compare_bus("b2b_bus");
    endtask

    task automatic test_clear();
        int  n;
        bit  stray;
        fill_all("clr_fill");
        compare_bus("clr_fill_bus");
        // Clear together with a write to reg 7: the write must be dropped.
        cr = 1'b1; we = 1'b1; wr = 5'd7; wd = 32'hFFFF_FFFF;
        tick();
        total++;
        if ({ack, err, busy} !== 3'b001) begin
            bad++;
            $display("FAIL clr_entry ack/err/busy: got %b want 001", {ack, err, busy});
        end
        // Keep hammering writes and clear requests; all must be ignored.
        n = 0;
        stray = 1'b0;
        for (int c = 0; c < 40 && busy === 1'b1; c++) begin
            n++;
            wr = 5'(c);
            tick();
            if (ack !== 1'b0 || err !== 1'b0) stray = 1'b1;
        end
        cr = 1'b0; we = 1'b0;
        total++;
        if (n != NR) begin
            bad++;
            $display("FAIL clr_busy_len: got %0d want %0d", n, NR);
        end
        total++;
        if (stray) begin
            bad++;
            $display("FAIL clr_ignore: got ack/err pulse want none");
        end
        model_zero();
        compare_bus("clr_bus");
        tick();
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL clr_no_restart: got busy=%b want 0", busy);
        end
    endtask

    task automatic test_reset_mid_clear();
        fill_all("rst_fill");
        cr = 1'b1;
        tick();
        cr = 1'b0;
        repeat (10) tick();
        total++;
        if (busy !== 1'b1 || bus[20*WL +: WL] !== model[20]) begin
            bad++;
            $display("FAIL rst_pre busy=%b slice20: got %h want %h", busy,
                     bus[20*WL +: WL], model[20]);
        end
        #2;
        reset = 1'b0;
        #1;
        model_zero();
        compare_bus("rst_async_bus");
        total++;
        if ({ack, err, busy} !== 3'b000) begin
            bad++;
            $display("FAIL rst_async_flags: got %b want 000", {ack, err, busy});
        end
        @(negedge clk);
        reset = 1'b1;
        tick();
        drive_write(31, 32'hA5A5_5A5A);
        tick();
        we = 1'b0;
        sb_check("rst_write31");
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL rst_write31_busy: got %b want 0", busy);
        end
    endtask

    task automatic test_out_of_range();
        logic [NR20*WL-1:0] snap;
        // Valid write first so the bus has content to keep.
        we20 = 1'b1; wr20 = 5'd19; wd20 = 32'hCAFE_0019;
        tick();
        total++;
        if ({ack20, err20} !== 2'b10 || bus20[19*WL +: WL] !== 32'hCAFE_0019) begin
            bad++;
            $display("FAIL oor_valid ack/err=%b slice19: got %h want CAFE0019",
                     {ack20, err20}, bus20[19*WL +: WL]);
        end
        snap = '0;
        snap[19*WL +: WL] = 32'hCAFE_0019;
        wr20 = 5'd22; wd20 = 32'hBAD0_0022;
        tick();
        we20 = 1'b0;
        total++;
        if ({ack20, err20} !== 2'b01) begin
            bad++;
            $display("FAIL oor_22 ack/err: got %b want 01", {ack20, err20});
        end
        total++;
        if (bus20 !== snap) begin
            bad++;
            $display("FAIL oor_22_bus: got changed want unchanged");
        end
        tick();
        total++;
        if (err20 !== 1'b0) begin
            bad++;
            $display("FAIL oor_err_len: got %b want 0", err20);
        end
        we20 = 1'b1; wr20 = 5'd31; wd20 = 32'hBAD0_0031;
        tick();
        we20 = 1'b0;
        total++;
        if ({ack20, err20} !== 2'b01 || bus20 !== snap) begin
            bad++;
            $display("FAIL oor_31 ack/err: got %b want 01 (bus unchanged)", {ack20, err20});
        end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_reg_zero();
        test_back_to_back();
        test_clear();
        test_reset_mid_clear();
        test_out_of_range();
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_leftover: got %0d want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_register_bank_writer
